// File: rtl/afe_adc_reader.sv
`default_nettype none
// ============================================================================
// Module   : afe_adc_reader
// Brief    : Paces, blanks and reads a serial 8-bit ADC; returns channel-tagged samples.
// Revision : 1.0
// ============================================================================
module afe_adc_reader #(
    parameter int unsigned CLK_DIV       = 4,
    parameter int unsigned SETTLE_CYCLES = 64,
    parameter int unsigned SAMPLE_PERIOD = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       LED_RED,
    input  logic       LED_IR,
    input  logic [6:0] DC_Comp,
    input  logic [3:0] PGA_Gain,
    input  logic [3:0] LED_Drive,
    input  logic       adc_sdo,
    output logic       adc_cs_n,
    output logic       adc_sclk,
    output logic [7:0] ADC,
    output logic       adc_valid,
    output logic       adc_chan,
    output logic       settle_busy
);

    localparam int unsigned c_set_w    = 17;
    localparam int unsigned c_settle_w = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned c_period_w = $clog2(SAMPLE_PERIOD);
    localparam int unsigned c_div_w    = $clog2(CLK_DIV);

    localparam logic [c_settle_w-1:0] c_settle_load = c_settle_w'(SETTLE_CYCLES);
    localparam logic [c_settle_w-1:0] c_settle_one  = c_settle_w'(1);
    localparam logic [c_period_w-1:0] c_period_last = c_period_w'(SAMPLE_PERIOD - 1);
    localparam logic [c_div_w-1:0]    c_div_last    = c_div_w'(CLK_DIV - 1);
    localparam logic [4:0]            c_half_last   = 5'd17;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t                  state_q,     state_d;
    logic [c_set_w-1:0]      settings_q,  settings_d;
    logic [c_settle_w-1:0]   settle_q,    settle_d;
    logic [c_period_w-1:0]   period_q,    period_d;
    logic [c_div_w-1:0]      div_q,       div_d;
    logic [4:0]              half_q,      half_d;
    logic [7:0]              shift_q,     shift_d;
    logic [7:0]              adc_q,       adc_d;
    logic                    cs_n_q,      cs_n_d;
    logic                    sclk_q,      sclk_d;
    logic                    valid_q,     valid_d;
    logic                    chan_q,      chan_d;
    logic                    chan_pend_q, chan_pend_d;

    logic [c_set_w-1:0]      settings_in;
    logic                    change;
    logic                    leds_ok;
    logic                    start_ok;
    logic                    div_wrap;

    assign settings_in = {LED_RED, LED_IR, DC_Comp, PGA_Gain, LED_Drive};
    assign change      = (settings_in != settings_q);
    assign leds_ok     = LED_RED ^ LED_IR;
    assign div_wrap    = (div_q == c_div_last);
    assign start_ok    = (period_q == '0) && (settle_q == '0) && leds_ok && !change;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            settings_q  <= settings_in;
            settle_q    <= c_settle_load;
            period_q    <= '0;
            div_q       <= '0;
            half_q      <= '0;
            shift_q     <= '0;
            adc_q       <= '0;
            cs_n_q      <= 1'b1;
            sclk_q      <= 1'b0;
            valid_q     <= 1'b0;
            chan_q      <= 1'b0;
            chan_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            settings_q  <= settings_d;
            settle_q    <= settle_d;
            period_q    <= period_d;
            div_q       <= div_d;
            half_q      <= half_d;
            shift_q     <= shift_d;
            adc_q       <= adc_d;
            cs_n_q      <= cs_n_d;
            sclk_q      <= sclk_d;
            valid_q     <= valid_d;
            chan_q      <= chan_d;
            chan_pend_q <= chan_pend_d;
        end
    end

    // The sample grid realigns to the end of every blanking window.
    always_comb begin
        settings_d = settings_in;
        settle_d   = settle_q;
        period_d   = (period_q == c_period_last) ? '0 : period_q + 1'b1;
        if (change) begin
            settle_d = c_settle_load;
        end else if (settle_q != '0) begin
            settle_d = settle_q - 1'b1;
            if (settle_q == c_settle_one) begin
                period_d = '0;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        half_d      = half_q;
        shift_d     = shift_q;
        adc_d       = adc_q;
        cs_n_d      = cs_n_q;
        sclk_d      = sclk_q;
        valid_d     = 1'b0;
        chan_d      = chan_q;
        chan_pend_d = chan_pend_q;

        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d     = ST_CONVERT;
                    cs_n_d      = 1'b0;
                    sclk_d      = 1'b0;
                    div_d       = '0;
                    half_d      = '0;
                    shift_d     = '0;
                    chan_pend_d = LED_IR;
                end
            end

            ST_CONVERT: begin
                if (change) begin
                    state_d = ST_IDLE;
                    cs_n_d  = 1'b1;
                    sclk_d  = 1'b0;
                end else if (div_wrap) begin
                    div_d  = '0;
                    half_d = half_q + 1'b1;
                    if (half_q == c_half_last) begin
                        state_d = ST_DONE;
                        sclk_d  = 1'b0;
                        cs_n_d  = 1'b1;
                        adc_d   = shift_q;
                        chan_d  = chan_pend_q;
                        valid_d = 1'b1;
                    end else begin
                        sclk_d = ~sclk_q;
                        // Even half-periods are rising edges; the first one is the mux edge.
                        if (!half_q[0] && (half_q != 5'd0)) begin
                            shift_d = {shift_q[6:0], adc_sdo};
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign adc_cs_n    = cs_n_q;
    assign adc_sclk    = sclk_q;
    assign ADC         = adc_q;
    assign adc_valid   = valid_q;
    assign adc_chan    = chan_q;
    assign settle_busy = (settle_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_afe_adc_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_afe_adc_reader
// Brief    : Directed bench with an event-level reference model and serial ADC responder.
// Revision : 1.0
// ============================================================================
module tb_afe_adc_reader;

    localparam int CD   = 4;
    localparam int SC   = 64;
    localparam int SP   = 1000;
    localparam int CONV = 18 * CD;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       LED_RED;
    logic       LED_IR;
    logic [6:0] DC_Comp;
    logic [3:0] PGA_Gain;
    logic [3:0] LED_Drive;
    logic       adc_sdo = 1'b0;
    logic       adc_cs_n;
    logic       adc_sclk;
    logic [7:0] ADC;
    logic       adc_valid;
    logic       adc_chan;
    logic       settle_busy;

    afe_adc_reader #(
        .CLK_DIV       (CD),
        .SETTLE_CYCLES (SC),
        .SAMPLE_PERIOD (SP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .LED_RED     (LED_RED),
        .LED_IR      (LED_IR),
        .DC_Comp     (DC_Comp),
        .PGA_Gain    (PGA_Gain),
        .LED_Drive   (LED_Drive),
        .adc_sdo     (adc_sdo),
        .adc_cs_n    (adc_cs_n),
        .adc_sclk    (adc_sclk),
        .ADC         (ADC),
        .adc_valid   (adc_valid),
        .adc_chan    (adc_chan),
        .settle_busy (settle_busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;

    // Reference model: a conversion is described only by its age in cycles.
    int          m_settle = 0;
    int          m_period = 0;
    int          m_conv   = -1;
    bit          m_done   = 1'b0;
    bit          m_valid  = 1'b0;
    bit          m_chan   = 1'b0;
    bit          m_pend   = 1'b0;
    logic [7:0]  m_adc    = 8'h00;
    logic [16:0] m_snap   = '0;
    bit          model_live = 1'b0;

    bit          alt_mode   = 1'b0;
    bit          alt_idx    = 1'b0;
    logic [7:0]  fixed_byte = 8'hA5;
    logic [7:0]  conv_byte  = 8'h00;

    always @(posedge clk) begin
        logic [16:0] s;
        bit          chg;
        bit          can_start;
        edge_n++;
        s       = {LED_RED, LED_IR, DC_Comp, PGA_Gain, LED_Drive};
        m_valid = 1'b0;
        if (!rst_n) begin
            m_settle   = SC;
            m_period   = 0;
            m_conv     = -1;
            m_done     = 1'b0;
            m_adc      = 8'h00;
            m_chan     = 1'b0;
            m_snap     = s;
            model_live = 1'b1;
        end else if (model_live) begin
            chg       = (s != m_snap);
            can_start = (m_conv < 0) && !m_done && (m_period == 0) && (m_settle == 0)
                        && (LED_RED != LED_IR) && !chg;
            m_done    = 1'b0;
            if (chg) begin
                m_snap = s;
                m_conv = -1;
            end else if (m_conv >= 0) begin
                if (m_conv + 1 == CONV) begin
                    m_adc   = conv_byte;
                    m_chan  = m_pend;
                    m_valid = 1'b1;
                    m_conv  = -1;
                    m_done  = 1'b1;
                end else begin
                    m_conv++;
                end
            end else if (can_start) begin
                m_conv = 0;
                m_pend = LED_IR;
                if (alt_mode) begin
                    conv_byte = alt_idx ? 8'hF0 : 8'h10;
                    alt_idx   = !alt_idx;
                end else begin
                    conv_byte = fixed_byte;
                end
            end
            if (chg) begin
                m_settle = SC;
                m_period = (m_period + 1) % SP;
            end else if (m_settle > 0) begin
                m_settle--;
                m_period = (m_settle == 0) ? 0 : (m_period + 1) % SP;
            end else begin
                m_period = (m_period + 1) % SP;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(posedge clk) begin
        bit exp_cs;
        bit exp_sclk;
        #1;
        if (model_live) begin
            exp_cs   = (m_conv < 0);
            exp_sclk = (m_conv >= 0) && (((m_conv / CD) % 2) == 1);
            checks++;
            if (adc_cs_n !== exp_cs || adc_sclk !== exp_sclk || ADC !== m_adc ||
                adc_valid !== m_valid || adc_chan !== m_chan || settle_busy !== (m_settle != 0)) begin
                failures++;
                $display("FAIL model_cmp edge=%0d got cs=%b sclk=%b adc=%h valid=%b chan=%b busy=%b required cs=%b sclk=%b adc=%h valid=%b chan=%b busy=%b",
                         edge_n, adc_cs_n, adc_sclk, ADC, adc_valid, adc_chan, settle_busy,
                         exp_cs, exp_sclk, m_adc, m_valid, m_chan, (m_settle != 0));
            end
        end
    end

    // Serial ADC responder and event monitor.
    int n_csfall = 0, csfall_edge = 0, rises = 0;
    int n_valid = 0, valid_edge = 0, rises_at_valid = 0, busy_fall_edge = 0;
    bit prev_cs = 1'b1, prev_sclk = 1'b0, prev_busy = 1'b0;

    always @(posedge clk) begin
        #1;
        if (prev_cs && !adc_cs_n) begin
            n_csfall++;
            csfall_edge = edge_n;
            rises       = 0;
            adc_sdo     = conv_byte[7];
        end
        if (!prev_sclk && adc_sclk) begin
            if (rises >= 1 && rises <= 7) adc_sdo = conv_byte[7 - rises];
            rises++;
        end
        if (adc_valid === 1'b1) begin
            n_valid++;
            valid_edge     = edge_n;
            rises_at_valid = rises;
        end
        if (prev_busy && !settle_busy) busy_fall_edge = edge_n;
        prev_cs   = adc_cs_n;
        prev_sclk = adc_sclk;
        prev_busy = settle_busy;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    task automatic wait_cs_fall(input string name, input int bound);
        int start = n_csfall;
        int i = 0;
        while (n_csfall == start && i < bound) begin
            @(negedge clk);
            i++;
        end
        chk({name, "_cs_fall_seen"}, (n_csfall != start), 1);
    endtask

    task automatic wait_valid(input string name, input int bound);
        int start = n_valid;
        int i = 0;
        while (n_valid == start && i < bound) begin
            @(negedge clk);
            i++;
        end
        chk({name, "_valid_seen"}, (n_valid != start), 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] alt_exp [3];
        int rst_edge, prev_v, ch_edge, nv, nf, s, i;
        alt_exp = '{8'h10, 8'hF0, 8'h10};

        rst_n = 1'b0; LED_RED = 1'b1; LED_IR = 1'b0;
        DC_Comp = 7'd0; PGA_Gain = 4'd0; LED_Drive = 4'd0;
        @(negedge clk);
        chk("rst_cs_n", adc_cs_n, 1);
        chk("rst_sclk", adc_sclk, 0);
        chk("rst_adc", ADC, 0);
        chk("rst_valid", adc_valid, 0);
        chk("rst_chan", adc_chan, 0);
        chk("rst_busy", settle_busy, 1);
        rst_edge = edge_n;
        rst_n = 1'b1;

        // First conversion after reset, RED channel, 0xA5.
        wait_cs_fall("first", 200);
        chk("settle_len", busy_fall_edge - rst_edge, SC);
        chk("first_start", csfall_edge - rst_edge, SC + 1);
        alt_mode = 1'b1;
        wait_valid("first", 200);
        chk("latency", valid_edge - csfall_edge, 72);
        chk("adc_a5", ADC, 8'hA5);
        chk("chan_red", adc_chan, 0);
        chk("sclk_rises", rises_at_valid, 9);

        // Steady state, alternating data.
        for (int k = 0; k < 3; k++) begin
            prev_v = valid_edge;
            wait_valid("steady", 1100);
            chk("period_gap", valid_edge - prev_v, SP);
            chk("alt_data", ADC, alt_exp[k]);
        end

        // Gain change after the 4th data bit aborts the conversion.
        wait_cs_fall("abort", 1100);
        i = 0;
        while (rises < 5 && i < 200) begin
            @(negedge clk);
            i++;
        end
        chk("abort_reach_bit4", rises, 5);
        PGA_Gain = 4'd1;
        ch_edge  = edge_n + 1;
        nv       = n_valid;
        @(negedge clk);
        chk("abort_cs_n", adc_cs_n, 1);
        chk("abort_sclk", adc_sclk, 0);
        wait_cs_fall("restart", 300);
        chk("abort_restart", csfall_edge - ch_edge, SC + 1);
        chk("abort_no_valid", n_valid, nv);
        chk("abort_adc_hold", ADC, 8'h10);
        wait_valid("restart", 200);

        // IR channel.
        alt_mode = 1'b0;
        fixed_byte = 8'h3C;
        LED_IR = 1'b1; LED_RED = 1'b0;
        wait_valid("ir", 1200);
        chk("adc_3c", ADC, 8'h3C);
        chk("chan_ir", adc_chan, 1);

        // Both LEDs on: no conversions at all.
        LED_RED = 1'b1;
        nf = n_csfall;
        repeat (3000) @(negedge clk);
        chk("both_on_no_start", n_csfall, nf);
        chk("both_on_cs_n", adc_cs_n, 1);

        // Reset at cycle 40 of a conversion.
        LED_IR = 1'b0;
        fixed_byte = 8'h5A;
        wait_cs_fall("rstmid", 1200);
        s = csfall_edge;
        while (edge_n < s + 39) @(negedge clk);
        nv = n_valid;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstmid_cs_n", adc_cs_n, 1);
        chk("rstmid_sclk", adc_sclk, 0);
        chk("rstmid_adc", ADC, 0);
        chk("rstmid_chan", adc_chan, 0);
        chk("rstmid_busy", settle_busy, 1);
        chk("rstmid_valid", adc_valid, 0);
        rst_n = 1'b1;
        rst_edge = edge_n;
        wait_cs_fall("after_rst", 200);
        chk("after_rst_start", csfall_edge - rst_edge, SC + 1);
        chk("rstmid_no_valid", n_valid, nv);
        wait_valid("after_rst", 200);
        chk("adc_5a", ADC, 8'h5A);

        // DC_Comp change on the exact completion edge.
        wait_cs_fall("collide", 1100);
        s = csfall_edge;
        while (edge_n < s + CONV - 1) @(negedge clk);
        DC_Comp = 7'h15;
        nv = n_valid;
        @(negedge clk);
        chk("collide_valid", adc_valid, 0);
        chk("collide_adc", ADC, 8'h5A);
        chk("collide_cs_n", adc_cs_n, 1);
        chk("collide_busy", settle_busy, 1);
        wait_cs_fall("collide_restart", 300);
        chk("collide_restart", csfall_edge - (s + CONV), SC + 1);
        chk("collide_no_valid", n_valid, nv);

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
